multicycle_cond_ctrl: RTL and testbench
=======================================

Name: multicycle_cond_ctrl

Overview:
- Main control FSM for the multicycle ARM-subset CPU core.
- Sequences fetch/decode/execute/memory/writeback and owns the architectural flag register {V,C,N,Z}.
- Drives the flags to the external condition checker and uses the returned CondEx to execute or skip each instruction.
- Sits between the instruction register and the datapath mux/enable controls.

Parameters:
- RESET_FLAGS, 4'b0000, reset value of the flag register {V,C,N,Z}.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- Op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
- Funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (memory: [0]=L)
- Rd  in  4  instr[15:12]
- ALUFlags  in  4  {V,C,N,Z} from ALU, current cycle
- CondEx  in  1  from condition checker, combinational on Flags and instr[31:28]
- Flags  out  4  registered {V,C,N,Z}
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  datapath enables
- AdrSrc  out  1  0=PC, 1=ALU result register
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU direct
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Illegal  out  1  one-cycle pulse on an illegal/undecodable instruction
- State  out  4  current state encoding, debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 are unreachable and recover to FETCH.
- Reset (rst_n=0 at a clk edge): State=FETCH, Flags=RESET_FLAGS. Reset mid-instruction aborts the instruction with no further enables.
- All outputs except Flags are combinational decodes of State plus the instruction fields. Every enable is 0 unless listed below.
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00. CondEx is sampled here against Flags.
  - CondEx=0: next state FETCH (instruction skipped, 2 cycles total).
  - Op=11 or undefined cmd: next state FETCH, Illegal=1.
  - Otherwise: Op=01 goes to MEMADR; Op=10 goes to BRANCH; Op=00 goes to EXECI if Funct[5]=1, else EXECR.
- Legal cmd values: 0100 ADD→00, 0010 SUB→01, 0000 AND→10, 1100 ORR→11, 1010 CMP→01. Any other cmd is illegal.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00 (R) or 01 (I), ALUControl from cmd.
  - Flag update at the state-exit edge, only if S=1. NZ always. CV only for ADD/SUB/CMP; AND/ORR keep the old CV.
  - CMP: next state FETCH, no writeback; CMP with S=0 is illegal. All other cmds: next state ALUWB.
- ALUWB: ResultSrc=00. If Rd≠15, RegWrite=1; if Rd=15, PCWrite=1 and RegWrite=0. Next state: FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00. Next state: MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1. Next state: MEMWB.
- MEMWB: ResultSrc=01, Rd=15 rule as in ALUWB. Next state: FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Next state: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=1. Next state: FETCH.
- Condition decision: CondEx is evaluated only once, in DECODE. Flags change only at EXEC exit, so the decision cannot change mid-instruction.
- Latency (cycles, including FETCH): DP=4, CMP=3, LDR=5, STR=4, B=3, skipped=2, illegal=2.
- Simultaneous events: rst_n=0 in an EXEC state with S=1 gives reset priority; Flags=RESET_FLAGS and no update occurs.

Test Plan:
- Reset then ADD R1 (Op=00, cmd=0100, S=1, I=0, CondEx=1, ALUFlags=4'b0101) -> State sequence 0,1,6,8,0; RegWrite=1 only in ALUWB; Flags=4'b0101 from the cycle after EXECR.
- ANDS with prior Flags=4'b1100 and ALUFlags=4'b0011 -> Flags=4'b1111 (CV held, NZ updated).
- CMP with I=1 and ALUFlags=4'b0001 -> states 0,1,7,0; RegWrite never asserted; Flags=4'b0001.
- LDR (Op=01, L=1, Rd=15) -> states 0,1,2,3,4,0; MEMWB asserts PCWrite=1 with RegWrite=0. STR -> states 0,1,2,5,0 with MemWrite=1 for exactly 1 cycle.
- CondEx=0 on a branch -> states 0,1,0; PCWrite=1 only during FETCH, Flags unchanged. Op=11 -> Illegal pulses for 1 cycle in DECODE.
- rst_n=0 asserted during MEMRD -> next State=0, Flags=RESET_FLAGS, no MemWrite/RegWrite pulse after reset.

Source files
------------

// File: rtl/multicycle_cond_ctrl.sv
// Main control FSM for the multicycle ARM-subset core: sequences each instruction
// through fetch/decode/execute/memory/writeback and owns the {V,C,N,Z} flag register.
module multicycle_cond_ctrl #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       CondEx,
  output logic [3:0] Flags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] flags;
  logic [3:0] cmd;
  logic       s_bit, cmd_legal, cmd_arith, is_cmp, bad_instr, rd_pc, in_exec;
  logic [1:0] alu_ctl;

  assign cmd     = Funct[4:1];
  assign s_bit   = Funct[0];
  assign rd_pc   = (Rd == 4'hF);
  assign in_exec = (state == EXECR) || (state == EXECI);

  // cmd decode: legality, ALU op, and whether the op produces meaningful C/V
  always_comb begin
    cmd_legal = 1'b1;
    cmd_arith = 1'b0;
    is_cmp    = 1'b0;
    alu_ctl   = 2'b00;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; cmd_arith = 1'b1; end
      4'b0000: alu_ctl = 2'b10;
      4'b1100: alu_ctl = 2'b11;
      4'b1010: begin alu_ctl = 2'b01; cmd_arith = 1'b1; is_cmp = 1'b1; end
      default: cmd_legal = 1'b0;
    endcase
  end

  // CMP without S would have no architectural effect, so it is rejected too
  assign bad_instr = (Op == 2'b11) ||
                     ((Op == 2'b00) && (!cmd_legal || (is_cmp && !s_bit)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      flags <= RESET_FLAGS;
    end else begin
      state <= state_nxt;
      if (in_exec && s_bit) begin
        flags[1:0] <= ALUFlags[1:0];
        if (cmd_arith) flags[3:2] <= ALUFlags[3:2];
      end
    end
  end

  always_comb begin
    state_nxt  = FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    Illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (!CondEx)        state_nxt = FETCH;
        else if (bad_instr) begin
          Illegal   = 1'b1;
          state_nxt = FETCH;
        end
        else if (Op == 2'b01) state_nxt = MEMADR;
        else if (Op == 2'b10) state_nxt = BRANCH;
        else                  state_nxt = Funct[5] ? EXECI : EXECR;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        state_nxt  = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        RegWrite = !rd_pc;
        PCWrite  = rd_pc;
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
        state_nxt = s_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = !rd_pc;
        PCWrite   = rd_pc;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign Flags = flags;
  assign State = state;

endmodule

// File: tb/tb_multicycle_cond_ctrl.sv
// Directed-vector bench for multicycle_cond_ctrl: walks each instruction class
// cycle by cycle against hand-computed states, enables and flags.
module tb_multicycle_cond_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, ALUFlags;
  logic       CondEx;
  logic [3:0] Flags, State;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl;

  int nvec = 0;
  int nmis = 0;

  multicycle_cond_ctrl #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .CondEx(CondEx), .Flags(Flags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock and sample away from the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                           input logic cx, input logic [3:0] af);
    Op = op; Funct = fn; Rd = rd; CondEx = cx; ALUFlags = af;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(2'b00, 6'b0_0100_1, 4'd1, 1'b1, 4'b0101);
    step();
    chk("rst_state", State, 0);
    chk("rst_flags", Flags, 4'b0000);
    step();
    rst_n = 1'b1;
    #1;

    // ADDS R1: 0,1,6,8,0
    chk("add_f_state", State, 0);
    chk("add_f_en", {IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc}, 8'b1101_1010);
    step(); chk("add_d_state", State, 1); chk("add_d_ill", Illegal, 0);
    chk("add_d_en", {PCWrite, RegWrite, ALUSrcA, ALUSrcB}, 5'b00110);
    step(); chk("add_e_state", State, 6);
    chk("add_e_alu", {ALUSrcA, ALUSrcB, ALUControl}, 5'b00000);
    chk("add_e_flags", Flags, 4'b0000); chk("add_e_rw", RegWrite, 0);
    step(); chk("add_wb_state", State, 8); chk("add_wb_rw", {RegWrite, PCWrite}, 2'b10);
    chk("add_wb_flags", Flags, 4'b0101); chk("add_wb_rs", ResultSrc, 2'b00);
    step(); chk("add_end_state", State, 0); chk("add_end_flags", Flags, 4'b0101);

    // SUBS to set Flags=1100
    set_instr(2'b00, 6'b0_0010_1, 4'd2, 1'b1, 4'b1100);
    step(); step(); chk("sub_e_alu", ALUControl, 2'b01);
    step(); chk("sub_wb_flags", Flags, 4'b1100);
    step();

    // ANDS: CV held, NZ updated -> 1111
    set_instr(2'b00, 6'b0_0000_1, 4'd3, 1'b1, 4'b0011);
    step(); step(); chk("and_e_state", State, 6); chk("and_e_alu", ALUControl, 2'b10);
    step(); chk("and_flags", Flags, 4'b1111);
    step();

    // ORR without S: flags unchanged
    set_instr(2'b00, 6'b0_1100_0, 4'd3, 1'b1, 4'b0000);
    step(); step(); chk("orr_e_alu", ALUControl, 2'b11);
    step(); chk("orr_noS_flags", Flags, 4'b1111);
    step();

    // CMP immediate: 0,1,7,0, no RegWrite
    set_instr(2'b00, 6'b1_1010_1, 4'd0, 1'b1, 4'b0001);
    step(); chk("cmp_d_rw", RegWrite, 0);
    step(); chk("cmp_e_state", State, 7);
    chk("cmp_e_alu", {ALUSrcA, ALUSrcB, ALUControl, RegWrite}, 6'b0_01_01_0);
    step(); chk("cmp_end_state", State, 0); chk("cmp_flags", Flags, 4'b0001);
    chk("cmp_end_rw", RegWrite, 0);

    // LDR PC: 0,1,2,3,4,0
    set_instr(2'b01, 6'b01100_1, 4'hF, 1'b1, 4'b1111);
    step(); step(); chk("ldr_a_state", State, 2);
    chk("ldr_a_alu", {ALUSrcA, ALUSrcB, ALUControl}, 5'b00100);
    step(); chk("ldr_r_state", State, 3); chk("ldr_r_adr", AdrSrc, 1);
    step(); chk("ldr_wb_state", State, 4);
    chk("ldr_wb_en", {PCWrite, RegWrite, ResultSrc}, 4'b1001);
    step(); chk("ldr_end_state", State, 0); chk("ldr_flags", Flags, 4'b0001);

    // STR: 0,1,2,5,0 with a single MemWrite cycle
    begin
      int mw = 0;
      logic [3:0] seq [5];
      logic [3:0] exp_seq [5];
      exp_seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      set_instr(2'b01, 6'b01100_0, 4'd2, 1'b1, 4'b0000);
      for (int i = 0; i < 5; i++) begin
        seq[i] = State;
        if (MemWrite) mw++;
        if (i == 3) chk("str_w_adr", {AdrSrc, RegWrite}, 2'b10);
        if (i < 4) step();
      end
      for (int i = 0; i < 5; i++) chk($sformatf("str_seq%0d", i), seq[i], exp_seq[i]);
      chk("str_mw_count", mw[7:0], 1);
    end

    // branch taken: 0,1,9,0
    set_instr(2'b10, 6'b000000, 4'd0, 1'b1, 4'b0000);
    step(); step(); chk("b_state", State, 9);
    chk("b_en", {PCWrite, ALUSrcB, ResultSrc}, 5'b10110);
    step(); chk("b_end_state", State, 0);

    // branch skipped: 0,1,0
    set_instr(2'b10, 6'b000000, 4'd0, 1'b0, 4'b1010);
    chk("bskip_f_pcw", PCWrite, 1);
    step(); chk("bskip_d_pcw", PCWrite, 0); chk("bskip_d_ill", Illegal, 0);
    step(); chk("bskip_end_state", State, 0); chk("bskip_flags", Flags, 4'b0001);

    // Op=11 illegal pulse
    set_instr(2'b11, 6'b0_0100_1, 4'd1, 1'b1, 4'b0000);
    chk("ill_f_ill", Illegal, 0);
    step(); chk("ill_d_ill", Illegal, 1);
    step(); chk("ill_end_state", State, 0); chk("ill_end_ill", Illegal, 0);

    // undefined cmd and CMP without S
    set_instr(2'b00, 6'b0_0001_1, 4'd1, 1'b1, 4'b0000);
    step(); chk("badcmd_ill", Illegal, 1);
    step(); chk("badcmd_state", State, 0);
    set_instr(2'b00, 6'b0_1010_0, 4'd1, 1'b1, 4'b0000);
    step(); chk("cmpnos_ill", Illegal, 1);
    step(); chk("cmpnos_state", State, 0);

    // reset during MEMRD
    set_instr(2'b01, 6'b01100_1, 4'd3, 1'b1, 4'b0000);
    step(); step(); step(); chk("rmr_state", State, 3);
    rst_n = 1'b0;
    step(); rst_n = 1'b1; #1;
    chk("rmr_state_after", State, 0); chk("rmr_flags", Flags, 4'b0000);
    begin
      int bad = 0;
      set_instr(2'b00, 6'b0_0100_1, 4'd1, 1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if (MemWrite || RegWrite) bad++;
        step();
      end
      chk("rmr_no_pulse", bad[7:0], 0);
    end

    // reset in EXEC with S=1: reset wins over flag update
    set_instr(2'b00, 6'b0_0100_1, 4'd1, 1'b1, 4'b1111);
    step(); step(); chk("rex_state", State, 6);
    rst_n = 1'b0;
    step(); rst_n = 1'b1; #1;
    chk("rex_state_after", State, 0); chk("rex_flags", Flags, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
